fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 142 ++++++++++++++
 tb/tb_fwd_scoreboard.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - pipeline destination scoreboard with operand forwarding and load-use stall
//
// Tracks the destination register of every in-flight instruction after decode
// (entry 0 youngest, entry NSTAGE-1 oldest). It picks the youngest in-flight
// producer for each decode source, muxes its result (or the register file value)
// onto the operand buses, and requests a stall while that producer's result is
// not ready yet.
//
// Optional feature: define FWD_PERF_EN to build the saturating stall-cycle counter.
// When FWD_PERF_EN is not defined, stall_count is tied to zero.
//
// Ports:
//   CLK, nRST                        clock, asynchronous active-low reset
//   advance                          pipeline enable; the scoreboard shifts only when high
//   flush                            kill the decode instruction (bubble, no stall)
//   issue_valid                      decode slot holds a real instruction
//   issue_rs/rt, issue_use_rs/rt     source selects and source-read flags
//   issue_wen, issue_wsel, issue_load  destination write enable, register, load flag
//   res_data, res_ready              per-stage result value and valid (stage k at [k*DW +: DW])
//   rf_rs_data, rf_rt_data           register file read data
//   stall                            hold decode and PC, insert bubble
//   fwd_a_sel, fwd_b_sel             0 = register file, k+1 = stage k
//   fwd_a_data, fwd_b_data           selected operands
//   stall_count                      stall-cycle counter
module fwd_scoreboard #(
    parameter int NREG   = 32,
    parameter int NSTAGE = 3,
    parameter int DW     = 32,
    localparam int RW    = $clog2(NREG),
    localparam int SW    = $clog2(NSTAGE + 1)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 advance,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [RW-1:0]        issue_rs,
    input  logic [RW-1:0]        issue_rt,
    input  logic                 issue_use_rs,
    input  logic                 issue_use_rt,
    input  logic                 issue_wen,
    input  logic [RW-1:0]        issue_wsel,
    input  logic                 issue_load,
    input  logic [NSTAGE*DW-1:0] res_data,
    input  logic [NSTAGE-1:0]    res_ready,
    input  logic [DW-1:0]        rf_rs_data,
    input  logic [DW-1:0]        rf_rt_data,
    output logic                 stall,
    output logic [SW-1:0]        fwd_a_sel,
    output logic [SW-1:0]        fwd_b_sel,
    output logic [DW-1:0]        fwd_a_data,
    output logic [DW-1:0]        fwd_b_data,
    output logic [31:0]          stall_count
);

    logic [NSTAGE-1:0] r_valid;
    logic [NSTAGE-1:0] r_load;
    logic [RW-1:0]     r_wsel [NSTAGE];

    logic w_enter;
    logic w_a_busy;
    logic w_b_busy;

    // Every producer, load or not, is gated by res_ready, so the load flag is
    // only carried along with the entry and never steers the stall decision.
    logic w_unused_load;
    assign w_unused_load = ^r_load;

    // Register 0 never enters, so its readers can never match an entry.
    assign w_enter = issue_valid & issue_wen & (issue_wsel != '0) & ~stall & ~flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
            r_load  <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                r_wsel[k] <= '0;
            end
        end else if (advance) begin
            for (int k = NSTAGE - 1; k >= 1; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_load[k]  <= r_load[k-1];
                r_wsel[k]  <= r_wsel[k-1];
            end
            r_valid[0] <= w_enter;
            r_load[0]  <= w_enter & issue_load;
            r_wsel[0]  <= issue_wsel;
        end
    end

    // Scan oldest to youngest so the youngest match is the last assignment.
    // Only the youngest match's readiness matters; older writers are shadowed.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        w_a_busy  = 1'b0;
        w_b_busy  = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (issue_use_rs && (issue_rs != '0) && r_valid[k] && (r_wsel[k] == issue_rs)) begin
                fwd_a_sel = SW'(k + 1);
                w_a_busy  = ~res_ready[k];
            end
            if (issue_use_rt && (issue_rt != '0) && r_valid[k] && (r_wsel[k] == issue_rt)) begin
                fwd_b_sel = SW'(k + 1);
                w_b_busy  = ~res_ready[k];
            end
        end
    end

    always_comb begin
        fwd_a_data = rf_rs_data;
        fwd_b_data = rf_rt_data;
        for (int k = 0; k < NSTAGE; k++) begin
            if (fwd_a_sel == SW'(k + 1)) begin
                fwd_a_data = res_data[k*DW +: DW];
            end
            if (fwd_b_sel == SW'(k + 1)) begin
                fwd_b_data = res_data[k*DW +: DW];
            end
        end
    end

    // A flushed decode slot is discarded anyway, so it must never hold the PC.
    assign stall = issue_valid & ~flush & (w_a_busy | w_b_busy);

`ifdef FWD_PERF_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_count <= '0;
        end else if (advance && stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - self-checking scoreboard bench for fwd_scoreboard
module tb_fwd_scoreboard;

    localparam logic [31:0] RF_RS = 32'hAAAA_0001;
    localparam logic [31:0] RF_RT = 32'hBBBB_0002;
    localparam logic [31:0] SV0   = 32'h1111_0000;
    localparam logic [31:0] SV1   = 32'h2222_0000;
    localparam logic [31:0] SV2   = 32'h3333_0000;
`ifdef FWD_PERF_EN
    localparam logic [31:0] PERF5 = 32'd5;
`else
    localparam logic [31:0] PERF5 = 32'd0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        advance, flush, issue_valid;
    logic [4:0]  issue_rs, issue_rt, issue_wsel;
    logic        issue_use_rs, issue_use_rt, issue_wen, issue_load;
    logic [95:0] res_data;
    logic [2:0]  res_ready;
    logic [31:0] rf_rs_data, rf_rt_data;
    logic        stall;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] fwd_a_data, fwd_b_data, stall_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit        v;
        int        rs;
        bit        urs;
        int        rt;
        bit        urt;
        bit        wen;
        int        wsel;
        bit        ld;
        bit [2:0]  rdy;
        bit        fl;
        bit        adv;
        bit        st;
        int        sa;
        int        sb;
        string     nm;
    } step_t;

    typedef struct {
        string       nm;
        bit          st;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [31:0] da;
        logic [31:0] db;
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    fwd_scoreboard dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .advance      (advance),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_wen    (issue_wen),
        .issue_wsel   (issue_wsel),
        .issue_load   (issue_load),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .rf_rs_data   (rf_rs_data),
        .rf_rt_data   (rf_rt_data),
        .stall        (stall),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .fwd_a_data   (fwd_a_data),
        .fwd_b_data   (fwd_b_data),
        .stall_count  (stall_count)
    );

    function automatic logic [31:0] exp_data(input int sel, input logic [31:0] rf);
        case (sel)
            1:       return SV0;
            2:       return SV1;
            3:       return SV2;
            default: return rf;
        endcase
    endfunction

    function automatic step_t mk(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                                 input bit wen, input int wsel, input bit ld, input bit [2:0] rdy,
                                 input bit fl, input bit adv, input bit st, input int sa, input int sb,
                                 input string nm);
        step_t s;
        s.v = v; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
        s.wen = wen; s.wsel = wsel; s.ld = ld; s.rdy = rdy; s.fl = fl; s.adv = adv;
        s.st = st; s.sa = sa; s.sb = sb; s.nm = nm;
        return s;
    endfunction

    task automatic apply(input step_t s);
        issue_valid  = s.v;
        issue_rs     = 5'(s.rs);
        issue_use_rs = s.urs;
        issue_rt     = 5'(s.rt);
        issue_use_rt = s.urt;
        issue_wen    = s.wen;
        issue_wsel   = 5'(s.wsel);
        issue_load   = s.ld;
        res_ready    = s.rdy;
        flush        = s.fl;
        advance      = s.adv;
    endtask

    task automatic push_exp(input step_t s);
        exp_t x;
        x.nm = s.nm;
        x.st = s.st;
        x.sa = 2'(s.sa);
        x.sb = 2'(s.sb);
        x.da = exp_data(s.sa, RF_RS);
        x.db = exp_data(s.sb, RF_RT);
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        step_t s;
        exp_t  e;
        nRST = 1'b0;
        s = mk(1, 5, 1, 6, 1, 1, 5, 1, 3'b000, 0, 1, 0, 0, 0, "reset_hold");
        apply(s);
        push_exp(s);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({stall, fwd_a_sel, fwd_b_sel} !== {e.st, e.sa, e.sb}) begin
            failures++;
            $display("FAIL %s stall/sel got=%0b/%0d/%0d exp=%0b/%0d/%0d", e.nm, stall, fwd_a_sel, fwd_b_sel, e.st, e.sa, e.sb);
        end
        checks++;
        if ({fwd_a_data, fwd_b_data} !== {e.da, e.db}) begin
            failures++;
            $display("FAIL %s data got=%h/%h exp=%h/%h", e.nm, fwd_a_data, fwd_b_data, e.da, e.db);
        end
        checks++;
        if (stall_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", stall_count);
        end
        @(negedge CLK);
        nRST = 1'b1;
        s = mk(1, 5, 1, 6, 1, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, "reset_no_entry");
        apply(s);
        push_exp(s);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({stall, fwd_a_sel, fwd_b_sel} !== {e.st, e.sa, e.sb}) begin
            failures++;
            $display("FAIL %s stall/sel got=%0b/%0d/%0d exp=%0b/%0d/%0d", e.nm, stall, fwd_a_sel, fwd_b_sel, e.st, e.sa, e.sb);
        end
        @(negedge CLK);
    endtask

    task automatic test_forward();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 3'b111, 0, 1, 0, 0, 0, "fwd_issue_r5"));
        s.push_back(mk(1, 5, 1, 9, 1, 0, 0, 0, 3'b111, 0, 1, 0, 1, 0, "fwd_stage0"));
        s.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 3'b111, 0, 1, 0, 2, 0, "fwd_stage1"));
        s.push_back(mk(1, 9, 0, 5, 1, 0, 0, 0, 3'b111, 0, 1, 0, 0, 3, "fwd_stage2_b"));
        s.push_back(mk(1, 5, 1, 5, 1, 0, 0, 0, 3'b111, 0, 1, 0, 0, 0, "fwd_retired"));
        foreach (s[i]) begin
            apply(s[i]);
            push_exp(s[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({stall, fwd_a_sel, fwd_b_sel} !== {e.st, e.sa, e.sb}) begin
                failures++;
                $display("FAIL %s stall/sel got=%0b/%0d/%0d exp=%0b/%0d/%0d", e.nm, stall, fwd_a_sel, fwd_b_sel, e.st, e.sa, e.sb);
            end
            checks++;
            if ({fwd_a_data, fwd_b_data} !== {e.da, e.db}) begin
                failures++;
                $display("FAIL %s data got=%h/%h exp=%h/%h", e.nm, fwd_a_data, fwd_b_data, e.da, e.db);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_load_stall();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 3'b111, 0, 1, 0, 0, 0, "ld_issue_r8"));
        s.push_back(mk(1, 12, 1, 8, 1, 1, 12, 0, 3'b110, 0, 1, 1, 0, 1, "ld_use_stall"));
        s.push_back(mk(1, 12, 1, 8, 1, 1, 12, 0, 3'b111, 0, 1, 0, 0, 2, "ld_ready_stage1"));
        s.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 3'b111, 0, 1, 0, 0, 3, "ld_stage2"));
        foreach (s[i]) begin
            apply(s[i]);
            push_exp(s[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({stall, fwd_a_sel, fwd_b_sel} !== {e.st, e.sa, e.sb}) begin
                failures++;
                $display("FAIL %s stall/sel got=%0b/%0d/%0d exp=%0b/%0d/%0d", e.nm, stall, fwd_a_sel, fwd_b_sel, e.st, e.sa, e.sb);
            end
            checks++;
            if ({fwd_a_data, fwd_b_data} !== {e.da, e.db}) begin
                failures++;
                $display("FAIL %s data got=%h/%h exp=%h/%h", e.nm, fwd_a_data, fwd_b_data, e.da, e.db);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_youngest();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 3'b111, 0, 1, 0, 0, 0, "yng_issue_r3_old"));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 3'b111, 0, 1, 0, 0, 0, "yng_issue_r7"));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 3'b111, 0, 1, 0, 0, 0, "yng_issue_r3_new"));
        s.push_back(mk(1, 3, 1, 7, 1, 0, 0, 0, 3'b011, 0, 0, 0, 1, 2, "yng_old_not_ready"));
        s.push_back(mk(1, 3, 1, 7, 1, 0, 0, 0, 3'b110, 0, 0, 1, 1, 2, "yng_young_not_ready"));
        foreach (s[i]) begin
            apply(s[i]);
            push_exp(s[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({stall, fwd_a_sel, fwd_b_sel} !== {e.st, e.sa, e.sb}) begin
                failures++;
                $display("FAIL %s stall/sel got=%0b/%0d/%0d exp=%0b/%0d/%0d", e.nm, stall, fwd_a_sel, fwd_b_sel, e.st, e.sa, e.sb);
            end
            checks++;
            if ({fwd_a_data, fwd_b_data} !== {e.da, e.db}) begin
                failures++;
                $display("FAIL %s data got=%h/%h exp=%h/%h", e.nm, fwd_a_data, fwd_b_data, e.da, e.db);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_r0();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 3'b000, 0, 1, 0, 0, 0, "r0_issue_write"));
        s.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, "r0_source"));
        foreach (s[i]) begin
            apply(s[i]);
            push_exp(s[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({stall, fwd_a_sel, fwd_b_sel} !== {e.st, e.sa, e.sb}) begin
                failures++;
                $display("FAIL %s stall/sel got=%0b/%0d/%0d exp=%0b/%0d/%0d", e.nm, stall, fwd_a_sel, fwd_b_sel, e.st, e.sa, e.sb);
            end
            checks++;
            if ({fwd_a_data, fwd_b_data} !== {e.da, e.db}) begin
                failures++;
                $display("FAIL %s data got=%h/%h exp=%h/%h", e.nm, fwd_a_data, fwd_b_data, e.da, e.db);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_flush_hold();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 3'b000, 0, 1, 0, 0, 0, "fl_issue_load"));
        s.push_back(mk(1, 8, 1, 0, 0, 1, 9, 0, 3'b000, 1, 1, 0, 1, 0, "fl_flush"));
        for (int c = 0; c < 4; c++) begin
            s.push_back(mk(1, 8, 1, 9, 1, 0, 0, 0, 3'b000, 0, 0, 1, 2, 0, "fl_hold"));
        end
        s.push_back(mk(1, 8, 1, 9, 1, 0, 0, 0, 3'b010, 0, 1, 0, 2, 0, "fl_release"));
        foreach (s[i]) begin
            apply(s[i]);
            push_exp(s[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({stall, fwd_a_sel, fwd_b_sel} !== {e.st, e.sa, e.sb}) begin
                failures++;
                $display("FAIL %s stall/sel got=%0b/%0d/%0d exp=%0b/%0d/%0d", e.nm, stall, fwd_a_sel, fwd_b_sel, e.st, e.sa, e.sb);
            end
            checks++;
            if ({fwd_a_data, fwd_b_data} !== {e.da, e.db}) begin
                failures++;
                $display("FAIL %s data got=%h/%h exp=%h/%h", e.nm, fwd_a_data, fwd_b_data, e.da, e.db);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_perf_reset();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 3'b000, 0, 1, 0, 0, 0, "pf_load_r8"));
        s.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 1, 0, "pf_stall_s0"));
        s.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 2, 0, "pf_stall_s1"));
        s.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 3, 0, "pf_stall_s2"));
        s.push_back(mk(1, 8, 1, 0, 0, 1, 10, 1, 3'b000, 0, 1, 0, 0, 0, "pf_load_r10"));
        s.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 1, 0, "pf_stall_r10_s0"));
        s.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 2, 0, "pf_stall_r10_s1"));
        s.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 3, 0, "pf_stall_r10_s2"));
        foreach (s[i]) begin
            apply(s[i]);
            push_exp(s[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({stall, fwd_a_sel, fwd_b_sel} !== {e.st, e.sa, e.sb}) begin
                failures++;
                $display("FAIL %s stall/sel got=%0b/%0d/%0d exp=%0b/%0d/%0d", e.nm, stall, fwd_a_sel, fwd_b_sel, e.st, e.sa, e.sb);
            end
            if (i < s.size() - 1) begin
                @(negedge CLK);
            end
        end
        checks++;
        if (stall_count !== PERF5) begin
            failures++;
            $display("FAIL pf_count got=%0d exp=%0d", stall_count, PERF5);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if ({stall, fwd_a_sel} !== {1'b0, 2'd0}) begin
            failures++;
            $display("FAIL pf_reset_stall stall/sel got=%0b/%0d exp=0/0", stall, fwd_a_sel);
        end
        checks++;
        if (stall_count !== 32'd0) begin
            failures++;
            $display("FAIL pf_reset_count got=%0d exp=0", stall_count);
        end
        checks++;
        if (fwd_a_data !== RF_RS) begin
            failures++;
            $display("FAIL pf_reset_data got=%h exp=%h", fwd_a_data, RF_RS);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if ({stall, fwd_a_sel} !== {1'b0, 2'd0}) begin
            failures++;
            $display("FAIL pf_after_reset stall/sel got=%0b/%0d exp=0/0", stall, fwd_a_sel);
        end
        @(negedge CLK);
    endtask

    initial begin
        nRST         = 1'b0;
        advance      = 1'b1;
        flush        = 1'b0;
        issue_valid  = 1'b0;
        issue_rs     = '0;
        issue_rt     = '0;
        issue_use_rs = 1'b0;
        issue_use_rt = 1'b0;
        issue_wen    = 1'b0;
        issue_wsel   = '0;
        issue_load   = 1'b0;
        res_data     = {SV2, SV1, SV0};
        res_ready    = '0;
        rf_rs_data   = RF_RS;
        rf_rt_data   = RF_RT;
        @(negedge CLK);
        test_reset();
        test_forward();
        test_load_stall();
        test_youngest();
        test_r0();
        test_flush_hold();
        test_perf_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
